// File: rtl/dm_ctrl_pkg.sv
// Shared types for the data-memory access controller: access-size codes,
// controller states and the alignment rule used to reject bad requests.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    DM_BYTE = 2'b00,
    DM_HALF = 2'b01,
    DM_RSVD = 2'b10,
    DM_WORD = 2'b11
  } dmop_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  // Reserved size, odd halfword and unaligned word accesses are refused.
  function automatic logic dm_legal(input logic [1:0] op, input logic [1:0] off);
    case (op)
      DM_BYTE: return 1'b1;
      DM_HALF: return ~off[0];
      DM_WORD: return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: lane enables and store replication from the live request,
// lane extraction and sign/zero extension of the returned read word.
module dm_lane
  import dm_ctrl_pkg::*;
(
  input  dmop_t       dmop,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  dmop_t       ld_dmop,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] rword,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword[{ld_off, 3'b000} +: 8];
  assign rhalf = ld_off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    be        = 4'b0000;
    wdata_rep = wdata;
    case (dmop)
      DM_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      DM_HALF: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      DM_WORD: be = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    rdata_ext = rword;
    case (ld_dmop)
      DM_BYTE: rdata_ext = {{24{ld_sext & rbyte[7]}}, rbyte};
      DM_HALF: rdata_ext = {{16{ld_sext & rhalf[15]}}, rhalf};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access controller: accepts one CPU load/store, drives a single
// word-wide memory request with lane enables, and returns a one-cycle ack.
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  DMop,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  dmop_t         ld_dmop;
  logic [1:0]    ld_off;
  logic          ld_sext;
  logic [3:0]    be_n;
  logic [31:0]   wrep_n;
  logic [31:0]   rdata_ext;

  dm_lane u_lane (
    .dmop      (dmop_t'(DMop)),
    .off       (addr[1:0]),
    .wdata     (wdata),
    .be        (be_n),
    .wdata_rep (wrep_n),
    .ld_dmop   (ld_dmop),
    .ld_off    (ld_off),
    .ld_sext   (ld_sext),
    .rword     (mem_rdata),
    .rdata_ext (rdata_ext)
  );

  // NOTE: all state here uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ld_dmop   <= DM_BYTE;
      ld_off    <= '0;
      ld_sext   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (dm_legal(DMop, addr[1:0])) begin
              state     <= S_ACCESS;
              cnt       <= '0;
              mem_en    <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wrep_n;
              ld_dmop   <= dmop_t'(DMop);
              ld_off    <= addr[1:0];
              ld_sext   <= sext;
            end else begin
              // Refused without touching memory.
              state <= S_RESP;
              ack   <= 1'b1;
              err   <= 1'b1;
              rdata <= '0;
            end
          end
        end
        S_ACCESS: begin
          // A ready in the final allowed cycle still completes normally.
          if (mem_ready) begin
            state  <= S_RESP;
            ack    <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            rdata  <= mem_we ? '0 : rdata_ext;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state  <= S_RESP;
            ack    <= 1'b1;
            err    <= 1'b1;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            rdata  <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
